// File: rtl/seg_display_mux_if.sv
// rtl/seg_display_mux_if.sv - value/strobe in, segment and digit-enable pins out for seg_display_mux
interface seg_display_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                value_valid;
    logic [DIGITS-1:0]   dp;
    logic                blank_lz;
    logic [7:0]          segReg;
    logic [DIGITS-1:0]   dsEN;

    modport master (
        output value,
        output value_valid,
        output dp,
        output blank_lz,
        input  segReg,
        input  dsEN
    );

    modport slave (
        input  value,
        input  value_valid,
        input  dp,
        input  blank_lz,
        output segReg,
        output dsEN
    );
endinterface

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - multiplexed hex 7-segment driver with dead time, blanking and flash-on-change
// Optional PWM dimming input enabled by defining SEG_DISPLAY_MUX_BRIGHTNESS_EN.
module seg_display_mux #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 25000,
    parameter int DEAD           = 64,
    parameter int FLASH_FRAMES   = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SEG_DISPLAY_MUX_BRIGHTNESS_EN
    input  logic [3:0]        brightness,
`endif
    seg_display_mux_if.slave  bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = $clog2(2 * FLASH_FRAMES + 2);

    localparam logic [PW-1:0]     PS_LAST    = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]     DEAD_END   = PW'(DEAD);
    localparam logic [SW-1:0]     SCAN_LAST  = SW'(DIGITS - 1);
    localparam logic [FW-1:0]     FLASH_LOAD = FW'(2 * FLASH_FRAMES);
    // XOR masks that turn active-high internal values into pin polarity; also the "all off" pattern.
    localparam logic [7:0]        SEG_OFF    = {8{SEG_ACTIVE_LOW != 0}};
    localparam logic [DIGITS-1:0] EN_OFF     = {DIGITS{EN_ACTIVE_LOW != 0}};

    generate
        if (PRESCALE < 2 || PRESCALE <= DEAD) begin : g_bad_prescale
            $error("seg_display_mux: PRESCALE must be >= 2 and > DEAD");
        end
        if (DIGITS < 1) begin : g_bad_digits
            $error("seg_display_mux: DIGITS must be >= 1");
        end
    endgenerate

    logic [PW-1:0]       presc;
    logic [SW-1:0]       scan;
    logic [4*DIGITS-1:0] pending;
    logic [4*DIGITS-1:0] shown;
    logic [4*DIGITS-1:0] shown_next;
    logic [FW-1:0]       flash_cnt;

    logic                slot_end;
    logic                frame_end;
    logic                dark;
    logic                bright_ok;
    logic                active;
    logic                blanked;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_zero;
    logic [DIGITS-1:0]   scan_onehot;
    logic [DIGITS-1:0]   zero_above;
    logic                lz_run;

    logic [7:0]          seg_hi;
    logic [DIGITS-1:0]   en_hi;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   en_next;
    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   en_q;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign slot_end   = (presc == PS_LAST);
    assign frame_end  = slot_end && (scan == SCAN_LAST);
    // A strobe landing on the boundary cycle goes straight to the display, skipping pending.
    assign shown_next = bus.value_valid ? bus.value : pending;
    assign dark       = (flash_cnt != '0) && !flash_cnt[0];

`ifdef SEG_DISPLAY_MUX_BRIGHTNESS_EN
    logic [3:0] presc_lo;
    generate
        if (PW >= 4) begin : g_plo_wide
            assign presc_lo = presc[3:0];
        end else begin : g_plo_narrow
            assign presc_lo = {{(4 - PW){1'b0}}, presc};
        end
    endgenerate
    assign bright_ok = (presc_lo <= brightness);
`else
    assign bright_ok = 1'b1;
`endif

    // zero_above[i] is set when nibbles DIGITS-1 down to i are all zero.
    always_comb begin
        zero_above = '0;
        lz_run     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run        = lz_run && (shown[4*i +: 4] == 4'h0);
            zero_above[i] = lz_run;
        end
    end

    always_comb begin
        cur_nib     = 4'h0;
        cur_dp      = 1'b0;
        cur_zero    = 1'b0;
        scan_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan == SW'(i)) begin
                cur_nib        = shown[4*i +: 4];
                cur_dp         = bus.dp[i];
                cur_zero       = zero_above[i];
                scan_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        seg_hi  = 8'h00;
        en_hi   = '0;
        active  = (presc >= DEAD_END) && !dark && bright_ok;
        blanked = bus.blank_lz && (scan != '0) && cur_zero;
        if (active) begin
            if (!blanked) begin
                en_hi  = scan_onehot;
                seg_hi = {cur_dp, glyph(cur_nib)};
            end else if (cur_dp) begin
                en_hi  = scan_onehot;
                seg_hi = 8'h80;
            end
        end
        seg_next = seg_hi ^ SEG_OFF;
        en_next  = en_hi ^ EN_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            scan      <= '0;
            pending   <= '0;
            shown     <= '0;
            flash_cnt <= '0;
        end else begin
            if (bus.value_valid) begin
                pending <= bus.value;
            end
            if (slot_end) begin
                presc <= '0;
                scan  <= (scan == SCAN_LAST) ? '0 : scan + SW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            if (frame_end) begin
                shown <= shown_next;
                if (shown_next != shown) begin
                    flash_cnt <= FLASH_LOAD;
                end else if (flash_cnt != '0) begin
                    flash_cnt <= flash_cnt - FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            en_q  <= EN_OFF;
        end else begin
            seg_q <= seg_next;
            en_q  <= en_next;
        end
    end

    assign bus.segReg = seg_q;
    assign bus.dsEN   = en_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - self-checking bench for seg_display_mux against a time-based reference model
module tb_seg_display_mux;

    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 8;
    localparam int DEAD         = 2;
    localparam int FLASH_FRAMES = 2;
    localparam int FRAME        = DIGITS * PRESCALE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
`ifdef SEG_DISPLAY_MUX_BRIGHTNESS_EN
    logic [3:0] brightness = 4'hF;
`endif

    seg_display_mux_if #(.DIGITS(DIGITS)) bus ();

    seg_display_mux #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD),
        .FLASH_FRAMES(FLASH_FRAMES), .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SEG_DISPLAY_MUX_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference: output position comes from the cycle count since reset, frame content from shown/flash.
    int          m_t;
    logic [15:0] m_pending;
    logic [15:0] m_shown;
    int          m_flash;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_en;

    function automatic logic [11:0] model_out(input int t, input logic [15:0] shown, input int flash,
                                              input logic [3:0] dp, input logic blz);
        int         phase;
        int         slot;
        logic [3:0] nib;
        phase = t % PRESCALE;
        slot  = (t / PRESCALE) % DIGITS;
        if (phase < DEAD) return 12'hFFF;
        if (flash != 0 && flash % 2 == 0) return 12'hFFF;
        nib = 4'((shown >> (4 * slot)) & 16'hF);
        if (blz && slot > 0 && (shown >> (4 * slot)) == 16'h0) begin
            if (dp[slot]) return {~8'h80, ~(4'b0001 << slot)};
            return 12'hFFF;
        end
        return {~{dp[slot], glyph_tab[nib]}, ~(4'b0001 << slot)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t       <= 0;
            m_pending <= 16'h0;
            m_shown   <= 16'h0;
            m_flash   <= 0;
            exp_seg   <= 8'hFF;
            exp_en    <= 4'hF;
        end else begin
            {exp_seg, exp_en} <= model_out(m_t, m_shown, m_flash, bus.dp, bus.blank_lz);
            if (m_t % FRAME == FRAME - 1) begin
                m_shown <= bus.value_valid ? bus.value : m_pending;
                if ((bus.value_valid ? bus.value : m_pending) != m_shown) m_flash <= 2 * FLASH_FRAMES;
                else if (m_flash > 0) m_flash <= m_flash - 1;
            end
            if (bus.value_valid) m_pending <= bus.value;
            m_t <= m_t + 1;
        end
    end

    // Frame position of the value currently on the output pins (one cycle behind the model clock).
    function automatic int out_pos();
        return (m_t - 1) % FRAME;
    endfunction

    task automatic wait_out(input int slot, input int phase);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_pos() != slot * PRESCALE + phase && n < 200);
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_out_timeout slot=%0d phase=%0d pos=%0d", slot, phase, out_pos());
        end
    endtask

    task automatic test_reset();
        int pos;
        rst_n = 1'b0;
        bus.value = 16'h0; bus.value_valid = 1'b0; bus.dp = 4'h0; bus.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.segReg !== 8'hFF) begin n_bad++; $display("FAIL reset_seg got %h want FF", bus.segReg); end
        n_cmp++;
        if (bus.dsEN !== 4'hF) begin n_bad++; $display("FAIL reset_en got %h want F", bus.dsEN); end
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            pos = out_pos();
            n_cmp++;
            if (bus.segReg !== exp_seg || bus.dsEN !== exp_en) begin
                n_bad++;
                $display("FAIL reset_scan pos=%0d seg=%h want %h en=%h want %h", pos, bus.segReg, exp_seg, bus.dsEN, exp_en);
            end
            if (pos == 2 || pos == 9 || pos == 10 || pos == 31) begin
                n_cmp++;
                if (bus.dsEN !== (pos == 2 ? 4'hE : pos == 9 ? 4'hF : pos == 10 ? 4'hD : 4'h7) ||
                    (pos != 9 && bus.segReg !== 8'hC0)) begin
                    n_bad++;
                    $display("FAIL reset_seq pos=%0d en=%h seg=%h", pos, bus.dsEN, bus.segReg);
                end
            end
        end
    endtask

    task automatic test_value_update();
        int pos;
        int fr;
        wait_out(1, 3);
        bus.value = 16'h005A; bus.value_valid = 1'b1;
        fr = 0;
        for (int i = 0; i < 7 * FRAME; i++) begin
            @(negedge clk);
            if (i == 0) bus.value_valid = 1'b0;
            pos = out_pos();
            if (pos == 0) fr++;
            n_cmp++;
            if (bus.segReg !== exp_seg || bus.dsEN !== exp_en) begin
                n_bad++;
                $display("FAIL update_model fr=%0d pos=%0d seg=%h want %h en=%h want %h", fr, pos, bus.segReg, exp_seg, bus.dsEN, exp_en);
            end
            if (fr == 0 && bus.dsEN !== 4'hF) begin
                n_cmp++;
                if (bus.segReg !== 8'hC0) begin n_bad++; $display("FAIL update_early pos=%0d seg=%h want C0", pos, bus.segReg); end
            end
            if (fr == 1 || fr == 3) begin
                n_cmp++;
                if (bus.dsEN !== 4'hF) begin n_bad++; $display("FAIL update_dark fr=%0d pos=%0d en=%h want F", fr, pos, bus.dsEN); end
            end
            if ((fr == 2 || fr >= 5) && pos % PRESCALE == 4) begin
                n_cmp++;
                if (bus.segReg !== (pos == 4 ? 8'h88 : pos == 12 ? 8'h92 : 8'hC0)) begin
                    n_bad++;
                    $display("FAIL update_glyph fr=%0d pos=%0d seg=%h", fr, pos, bus.segReg);
                end
            end
        end
    endtask

    task automatic test_same_value();
        int pos;
        for (int i = 0; i < 330; i++) begin
            @(negedge clk);
            bus.value_valid = (i == 0 || i == 100 || i == 200);
            bus.value = 16'h005A;
            pos = out_pos();
            n_cmp++;
            if (bus.segReg !== exp_seg || bus.dsEN !== exp_en) begin
                n_bad++;
                $display("FAIL same_model pos=%0d seg=%h want %h en=%h want %h", pos, bus.segReg, exp_seg, bus.dsEN, exp_en);
            end
            if (pos % PRESCALE >= DEAD) begin
                n_cmp++;
                if (bus.dsEN === 4'hF) begin n_bad++; $display("FAIL same_no_dark pos=%0d en=%h want lit", pos, bus.dsEN); end
            end
        end
        bus.value_valid = 1'b0;
    endtask

    task automatic test_blanking();
        int pos;
        bus.blank_lz = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (i == 2 * FRAME) bus.dp = 4'b1000;
            pos = out_pos();
            n_cmp++;
            if (bus.segReg !== exp_seg || bus.dsEN !== exp_en) begin
                n_bad++;
                $display("FAIL blank_model pos=%0d seg=%h want %h en=%h want %h", pos, bus.segReg, exp_seg, bus.dsEN, exp_en);
            end
            if (i < 2 * FRAME && pos >= 2 * PRESCALE && pos % PRESCALE >= DEAD) begin
                n_cmp++;
                if (bus.dsEN !== 4'hF) begin n_bad++; $display("FAIL blank_off pos=%0d en=%h want F", pos, bus.dsEN); end
            end
            if (i > 2 * FRAME + 1 && pos >= 3 * PRESCALE + DEAD) begin
                n_cmp++;
                if (bus.dsEN !== 4'h7 || bus.segReg !== 8'h7F) begin
                    n_bad++;
                    $display("FAIL blank_dp pos=%0d en=%h seg=%h want 7/7F", pos, bus.dsEN, bus.segReg);
                end
            end
        end
        bus.dp = 4'h0;
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_boundary_strobe();
        int pos;
        int fr;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_t % FRAME != FRAME - 1 && n < 100);
        n_cmp++;
        if (n >= 100) begin n_bad++; $display("FAIL boundary_wait timeout m_t=%0d", m_t); end
        bus.value = 16'h1234; bus.value_valid = 1'b1;
        fr = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (i == 0) bus.value_valid = 1'b0;
            pos = out_pos();
            if (pos == 0) fr++;
            n_cmp++;
            if (bus.segReg !== exp_seg || bus.dsEN !== exp_en) begin
                n_bad++;
                $display("FAIL boundary_model fr=%0d pos=%0d seg=%h want %h en=%h want %h", fr, pos, bus.segReg, exp_seg, bus.dsEN, exp_en);
            end
            if (fr == 1) begin
                n_cmp++;
                if (bus.dsEN !== 4'hF) begin n_bad++; $display("FAIL boundary_dark pos=%0d en=%h want F", pos, bus.dsEN); end
            end
            if (fr == 2 && pos % PRESCALE == 5) begin
                n_cmp++;
                if (bus.segReg !== (pos == 5 ? 8'h99 : pos == 13 ? 8'hB0 : pos == 21 ? 8'hA4 : 8'hF9)) begin
                    n_bad++;
                    $display("FAIL boundary_glyph pos=%0d seg=%h", pos, bus.segReg);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int pos;
        wait_out(1, 4);
        n_cmp++;
        if (bus.dsEN !== 4'hD) begin n_bad++; $display("FAIL areset_pre en=%h want D", bus.dsEN); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.segReg !== 8'hFF || bus.dsEN !== 4'hF) begin
            n_bad++;
            $display("FAIL areset_immediate seg=%h en=%h want FF/F", bus.segReg, bus.dsEN);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            pos = out_pos();
            n_cmp++;
            if (bus.segReg !== exp_seg || bus.dsEN !== exp_en) begin
                n_bad++;
                $display("FAIL areset_model pos=%0d seg=%h want %h en=%h want %h", pos, bus.segReg, exp_seg, bus.dsEN, exp_en);
            end
            if (i < PRESCALE && pos >= DEAD && pos < PRESCALE) begin
                n_cmp++;
                if (bus.dsEN !== 4'hE || bus.segReg !== 8'hC0) begin
                    n_bad++;
                    $display("FAIL areset_restart pos=%0d en=%h seg=%h want E/C0", pos, bus.dsEN, bus.segReg);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [4];
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.segReg !== exp_seg || bus.dsEN !== exp_en) begin
                n_bad++;
                $display("FAIL random_model i=%0d pos=%0d seg=%h want %h en=%h want %h", i, out_pos(), bus.segReg, exp_seg, bus.dsEN, exp_en);
            end
            pool[0] = 16'h0000; pool[1] = 16'h005A; pool[2] = 16'h00F0; pool[3] = 16'($urandom);
            bus.value_valid = ($urandom_range(0, 99) < 2);
            bus.value = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 49) == 0) bus.dp = 4'($urandom);
            if ($urandom_range(0, 199) == 0) bus.blank_lz = ~bus.blank_lz;
        end
        bus.value_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_value_update();
        test_same_value();
        test_blanking();
        test_boundary_strobe();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
